intr_ctrl: RTL and testbench

Interrupt request controller that drives the `intr` input of the PC control unit. It synchronizes an asynchronous external interrupt line, latches rising edges as a one-deep pending request, and issues `intr` only at an instruction boundary (`instr_done`) where redirecting the PC is safe. It then masks further interrupts until the service routine's RTI retires. It sits between the external IRQ pin and the PC control unit, and monitors the same `opcode`/`brx` decode fields.

---
 rtl/intr_ctrl.sv | 82 ++++++++
 tb/tb_intr_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Interrupt request controller: synchronizes irq_in, latches a one-deep pending request,
// and issues intr only at a safe (non control-flow) instruction boundary.
module intr_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       irq_in,
   input  logic       int_en,
   input  logic       instr_done,
   input  logic [3:0] opcode,
   input  logic [1:0] brx,
   input  logic       overrun_clr,
   output logic       intr,
   output logic       in_service,
   output logic       irq_pending,
   output logic       irq_overrun
);

   typedef enum logic {
      IDLE    = 1'b0,
      SERVICE = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_d_q;
   logic                   pending_q, pending_d;
   logic                   overrun_q, overrun_d;
   logic                   irq_edge;
   logic                   ctl;
   logic                   rti;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q    <= '0;
         sync_d_q  <= 1'b0;
         state_q   <= IDLE;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_in};
         sync_d_q  <= sync_q[SYNC_STAGES-1];
         state_q   <= state_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign irq_edge = sync_q[SYNC_STAGES-1] & ~sync_d_q;

   // Issuing on a branch/LOOP/JMP boundary would override the redirect in the PC unit.
   assign ctl = (opcode == 4'd9) | (opcode == 4'd10) | (opcode == 4'd11);
   assign rti = instr_done & (opcode == 4'd11) & (brx == 2'd3);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      overrun_d = overrun_q;
      intr      = 1'b0;
      case (state_q)
         IDLE: begin
            intr = pending_q & int_en & instr_done & ~ctl;
            if (intr) state_d = SERVICE;
         end
         SERVICE: begin
            if (rti) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A new edge in the issue cycle becomes the next request rather than an overrun.
      if (intr)                         pending_d = 1'b0;
      if (irq_edge)                     pending_d = 1'b1;
      if (overrun_clr)                  overrun_d = 1'b0;
      if (irq_edge & pending_q & ~intr) overrun_d = 1'b1;
   end

   assign in_service  = (state_q == SERVICE);
   assign irq_pending = pending_q;
   assign irq_overrun = overrun_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: a reference model built from the sample history of irq_in
// pushes per-cycle expected outputs; a negedge monitor pops and compares.
module tb_intr_ctrl;
   localparam int S = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       irq_in;
   logic       int_en;
   logic       instr_done;
   logic [3:0] opcode;
   logic [1:0] brx;
   logic       overrun_clr;
   logic       intr;
   logic       in_service;
   logic       irq_pending;
   logic       irq_overrun;

   intr_ctrl #(.SYNC_STAGES(S)) dut (
      .clk         (clk),
      .reset       (reset),
      .irq_in      (irq_in),
      .int_en      (int_en),
      .instr_done  (instr_done),
      .opcode      (opcode),
      .brx         (brx),
      .overrun_clr (overrun_clr),
      .intr        (intr),
      .in_service  (in_service),
      .irq_pending (irq_pending),
      .irq_overrun (irq_overrun)
   );

   always #5 clk = ~clk;

   logic [3:0] exp_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         dut_issues = 0;
   bit         count_on = 1'b0;

   // Reference state: irq_in samples taken at each clock edge, newest first.
   bit hist[$];
   bit m_pend, m_svc, m_ovr;
   bit p_intr, p_edge, p_rti, p_clr, p_irq;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i <= S; i++) hist.push_back(1'b0);
      m_pend = 0; m_svc = 0; m_ovr = 0;
      p_intr = 0; p_edge = 0; p_rti = 0; p_clr = 0; p_irq = 0;
   endtask

   task automatic cycle(input bit irq, input bit en, input bit done,
                        input logic [3:0] op, input logic [1:0] bx, input bit clr);
      bit np;
      @(posedge clk);
      #1;
      np = p_edge ? 1'b1 : (p_intr ? 1'b0 : m_pend);
      if (p_edge && m_pend && !p_intr) m_ovr = 1'b1;
      else if (p_clr)                  m_ovr = 1'b0;
      if (p_intr)                m_svc = 1'b1;
      else if (m_svc && p_rti)   m_svc = 1'b0;
      m_pend = np;
      hist.push_front(p_irq);
      void'(hist.pop_back());

      irq_in = irq; int_en = en; instr_done = done;
      opcode = op; brx = bx; overrun_clr = clr;
      p_irq  = irq;
      p_clr  = clr;
      p_rti  = done && (op == 4'd11) && (bx == 2'd3);
      p_edge = hist[S-1] && !hist[S];
      p_intr = !m_svc && m_pend && en && done && !(op inside {4'd9, 4'd10, 4'd11});
      exp_q.push_back({p_intr, m_svc, m_pend, m_ovr});
   endtask

   task automatic nop(input int n, input bit irq, input bit en);
      for (int i = 0; i < n; i++) cycle(irq, en, 1'b0, 4'd0, 2'd0, 1'b0);
   endtask

   task automatic bnd(input bit irq, input bit en, input logic [3:0] op, input logic [1:0] bx);
      cycle(irq, en, 1'b1, op, bx, 1'b0);
   endtask

   task automatic pulse(input bit en);
      cycle(1'b1, en, 1'b0, 4'd0, 2'd0, 1'b0);
   endtask

   always @(negedge clk) begin
      logic [3:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("outputs{intr,in_service,pending,overrun}",
               {intr, in_service, irq_pending, irq_overrun}, e);
         if (count_on && intr) dut_issues++;
      end
   end

   initial begin
      irq_in = 0; int_en = 0; instr_done = 0; opcode = 0; brx = 0; overrun_clr = 0;
      reset = 0;
      #1 reset = 1;
      #2;
      check("reset_outputs", {intr, in_service, irq_pending, irq_overrun}, 0);
      repeat (2) @(posedge clk);
      #3 reset = 0;
      model_reset();

      // Basic issue, then RTI
      nop(2, 0, 1);
      pulse(1);
      nop(3, 0, 1);
      bnd(0, 1, 4'd2, 2'd0);
      nop(2, 0, 1);
      bnd(0, 1, 4'd11, 2'd3);
      nop(2, 0, 1);

      // Deferral over control-flow boundaries
      pulse(1);
      nop(3, 0, 1);
      bnd(0, 1, 4'd9, 2'd0);
      bnd(0, 1, 4'd11, 2'd0);
      bnd(0, 1, 4'd10, 2'd1);
      bnd(0, 1, 4'd2, 2'd0);
      bnd(0, 1, 4'd11, 2'd3);
      nop(2, 0, 1);

      // Second request during service, issued after RTI
      pulse(1);
      nop(3, 0, 1);
      bnd(0, 1, 4'd3, 2'd0);
      pulse(1);
      nop(3, 0, 1);
      bnd(0, 1, 4'd1, 2'd0);
      bnd(0, 1, 4'd11, 2'd3);
      bnd(0, 1, 4'd5, 2'd0);
      bnd(0, 1, 4'd11, 2'd3);
      nop(2, 0, 1);

      // Overrun, clear, then coincident edge and issue
      pulse(1);
      nop(3, 0, 1);
      pulse(1);
      nop(3, 0, 1);
      cycle(0, 1, 0, 4'd0, 2'd0, 1'b1);
      nop(2, 0, 1);
      pulse(1);
      nop(1, 0, 1);
      bnd(0, 1, 4'd2, 2'd0);
      nop(2, 0, 1);
      bnd(0, 1, 4'd11, 2'd3);
      bnd(0, 1, 4'd4, 2'd0);
      bnd(0, 1, 4'd11, 2'd3);
      nop(2, 0, 1);

      // Enable gating
      pulse(0);
      nop(3, 0, 0);
      bnd(0, 0, 4'd2, 2'd0);
      bnd(0, 0, 4'd6, 2'd0);
      bnd(0, 0, 4'd7, 2'd0);
      bnd(0, 1, 4'd9, 2'd0);
      bnd(0, 1, 4'd8, 2'd0);
      nop(1, 0, 0);
      bnd(0, 0, 4'd11, 2'd3);
      nop(2, 0, 1);

      // Asynchronous reset while in service with a request pending
      pulse(1);
      nop(3, 0, 1);
      bnd(0, 1, 4'd2, 2'd0);
      pulse(1);
      nop(3, 0, 1);
      #6;
      irq_in = 0;
      reset = 1;
      #1;
      check("async_reset_outputs", {intr, in_service, irq_pending, irq_overrun}, 0);
      repeat (2) @(posedge clk);
      #3 reset = 0;
      model_reset();

      // Level held high for 20 cycles gives a single issue
      count_on = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) bnd(1, 1, 4'd2, 2'd0);
         else            bnd(1, 1, 4'd11, 2'd3);
      end
      for (int i = 0; i < 3; i++) bnd(0, 1, 4'd2, 2'd0);
      #5;
      count_on = 1'b0;
      check("level_irq_issue_count", dut_issues, 1);
      bnd(0, 1, 4'd11, 2'd3);
      nop(4, 0, 1);

      // Randomized traffic
      begin
         bit         r_irq;
         bit         r_en;
         bit         r_done;
         bit         r_clr;
         logic [3:0] r_op;
         logic [1:0] r_bx;
         int         sel;
         r_irq = 0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) r_irq = ~r_irq;
            r_en   = ($urandom_range(0, 9) != 0);
            r_done = ($urandom_range(0, 2) == 0);
            r_clr  = ($urandom_range(0, 15) == 0);
            r_bx   = 2'($urandom_range(0, 3));
            sel    = $urandom_range(0, 7);
            case (sel)
               0: r_op = 4'd9;
               1: r_op = 4'd10;
               2: r_op = 4'd11;
               3: begin r_op = 4'd11; r_bx = 2'd3; end
               default: r_op = 4'($urandom_range(0, 15));
            endcase
            cycle(r_irq, r_en, r_done, r_op, r_bx, r_clr);
         end
      end

      #6;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
